// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port, variable-latency word memory between the
//   instruction-fetch port and the data (load/store) port of the multicycle
//   MIPS core. Round-robin on simultaneous requests; a watchdog aborts a
//   transaction the memory never acknowledges.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   if_req/if_addr    fetch request (level) and word address
//   if_rdata/if_done  fetched word (held) and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata  data request, store enable, address, store data
//   d_rdata/d_done    load data (held) and one-cycle completion pulse
//   err               set with a done pulse when the transaction timed out
//   m_req/m_we/m_addr/m_wdata  memory request side, held stable while busy
//   m_rdata/m_ack     memory read data and completion pulse
//   owner             0 = fetch port, 1 = data port (current or last grant)
module mem_arbiter #(
    parameter int AW      = 30,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          err,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          owner
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam bit          WD_EN = (TIMEOUT != 0);
    localparam logic [31:0] TERM  = 32'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]  state;
    logic        last_owner;
    logic [31:0] wait_cnt;
    logic        winner;

    // On a tie the port that was not served last wins.
    always_comb begin
        winner = d_req;
        if (if_req && d_req)
            winner = ~last_owner;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            wait_cnt   <= '0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            if_rdata   <= '0;
            d_rdata    <= '0;
            if_done    <= 1'b0;
            d_done     <= 1'b0;
            err        <= 1'b0;
            owner      <= 1'b0;
        end else begin
            // Done and err are single-cycle pulses, asserted only in DONE.
            if_done <= 1'b0;
            d_done  <= 1'b0;
            err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        owner    <= winner;
                        m_req    <= 1'b1;
                        wait_cnt <= '0;
                        state    <= BUSY;
                        if (winner) begin
                            m_addr  <= d_addr;
                            m_we    <= d_we;
                            m_wdata <= d_wdata;
                        end else begin
                            m_addr  <= if_addr;
                            m_we    <= 1'b0;
                            m_wdata <= '0;
                        end
                    end
                end
                BUSY: begin
                    // An ack on the terminal-count cycle wins over the watchdog.
                    if (m_ack) begin
                        if (!m_we) begin
                            if (owner) d_rdata  <= m_rdata;
                            else       if_rdata <= m_rdata;
                        end
                        last_owner <= owner;
                        m_req      <= 1'b0;
                        if (owner) d_done  <= 1'b1;
                        else       if_done <= 1'b1;
                        state      <= DONE;
                    end else if (WD_EN && wait_cnt == TERM) begin
                        m_req <= 1'b0;
                        err   <= 1'b1;
                        if (owner) d_done  <= 1'b1;
                        else       if_done <= 1'b1;
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 32'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Self-checking bench for mem_arbiter. A memory responder acks after a
//   programmable number of m_req cycles; per-port scoreboards hold the
//   expected completion of every request driven and are popped on done.
module tb_mem_arbiter;

    localparam int AW = 30;
    localparam int DW = 32;
    localparam int TO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          err;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ack;
    logic          owner;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_done(d_done), .err(err),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack), .owner(owner)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic        err;
        logic        store;
        logic [31:0] rdata;
    } exp_t;

    exp_t        q_if[$];
    exp_t        q_d[$];
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_d_rdata  = '0;

    logic [31:0] mem [logic [29:0]];
    int          lat      = 1;
    bit          idle_ack = 1'b0;
    int          rcnt     = 0;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        if (mem.exists(a)) return mem[a];
        return {2'b10, a} ^ 32'h5A5A_0000;
    endfunction

    // Memory responder: ack in the lat-th cycle of m_req (lat=0: never).
    initial begin
        m_ack   = 1'b0;
        m_rdata = '0;
        forever begin
            @(negedge clk);
            if (m_req && !rst) begin
                rcnt++;
                if (lat != 0 && rcnt == lat) begin
                    m_ack   = 1'b1;
                    m_rdata = mem_word(m_addr);
                    if (m_we) mem[m_addr] = m_wdata;
                end else begin
                    m_ack   = 1'b0;
                    m_rdata = $urandom;
                end
            end else begin
                rcnt    = 0;
                m_ack   = idle_ack;
                m_rdata = $urandom;
            end
        end
    end

    // Completion monitor / scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            check("done_excl", {63'b0, if_done & d_done}, 64'd0);
            if (if_done) begin
                check("if_pending", {63'b0, q_if.size() != 0}, 64'd1);
                if (q_if.size() != 0) begin
                    e = q_if.pop_front();
                    check("if_err", {63'b0, err}, {63'b0, e.err});
                    check("if_owner", {63'b0, owner}, 64'd0);
                    if (!e.err) exp_if_rdata = e.rdata;
                end
            end
            if (d_done) begin
                check("d_pending", {63'b0, q_d.size() != 0}, 64'd1);
                if (q_d.size() != 0) begin
                    e = q_d.pop_front();
                    check("d_err", {63'b0, err}, {63'b0, e.err});
                    check("d_owner", {63'b0, owner}, 64'd1);
                    if (!e.err && !e.store) exp_d_rdata = e.rdata;
                end
            end
            check("err_qual", {63'b0, err & ~(if_done | d_done)}, 64'd0);
            check("if_rdata", {32'b0, if_rdata}, {32'b0, exp_if_rdata});
            check("d_rdata", {32'b0, d_rdata}, {32'b0, exp_d_rdata});
        end
    end

    task automatic push_if(input logic [29:0] a, input logic e);
        exp_t x;
        x.err   = e;
        x.store = 1'b0;
        x.rdata = mem_word(a);
        q_if.push_back(x);
        if_addr = a;
        if_req  = 1'b1;
    endtask

    task automatic push_d(input logic we, input logic [29:0] a, input logic [31:0] wd, input logic e);
        exp_t x;
        x.err   = e;
        x.store = we;
        x.rdata = mem_word(a);
        q_d.push_back(x);
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_req"},   {63'b0, m_req}, 64'd0);
        check({tag, "_m_we"},    {63'b0, m_we}, 64'd0);
        check({tag, "_m_addr"},  {34'b0, m_addr}, 64'd0);
        check({tag, "_m_wdata"}, {32'b0, m_wdata}, 64'd0);
        check({tag, "_if_rd"},   {32'b0, if_rdata}, 64'd0);
        check({tag, "_d_rd"},    {32'b0, d_rdata}, 64'd0);
        check({tag, "_if_done"}, {63'b0, if_done}, 64'd0);
        check({tag, "_d_done"},  {63'b0, d_done}, 64'd0);
        check({tag, "_err"},     {63'b0, err}, 64'd0);
        check({tag, "_owner"},   {63'b0, owner}, 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        bit got;
        bit port;
        int raised;
        rst = 1'b1; if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst0");
        rst = 1'b0;
        @(negedge clk);

        // Fetch with ack in cycle 3.
        mem[30'h10] = 32'h2008000A;
        lat = 3;
        push_if(30'h10, 1'b0);
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            check("f_m_req", {63'b0, m_req}, 64'd1);
            check("f_m_addr", {34'b0, m_addr}, 64'h10);
            check("f_m_we", {63'b0, m_we}, 64'd0);
            check("f_d_done", {63'b0, d_done}, 64'd0);
        end
        @(negedge clk);
        check("f_if_done", {63'b0, if_done}, 64'd1);
        check("f_d_done4", {63'b0, d_done}, 64'd0);
        check("f_m_req4", {63'b0, m_req}, 64'd0);
        check("f_rdata", {32'b0, if_rdata}, 64'h2008000A);
        if_req = 1'b0;
        @(negedge clk);

        // Store, ack after one cycle.
        lat = 1;
        push_d(1'b1, 30'h20, 32'hDEADBEEF, 1'b0);
        @(negedge clk);
        check("s_m_req", {63'b0, m_req}, 64'd1);
        check("s_m_we", {63'b0, m_we}, 64'd1);
        check("s_m_wdata", {32'b0, m_wdata}, 64'hDEADBEEF);
        check("s_m_addr", {34'b0, m_addr}, 64'h20);
        @(negedge clk);
        check("s_d_done", {63'b0, d_done}, 64'd1);
        check("s_mem", {32'b0, mem_word(30'h20)}, 64'hDEADBEEF);
        d_req = 1'b0;
        @(negedge clk);

        // Simultaneous requests: strict alternation, 4 transactions.
        lat = 2;
        raised = 2;
        push_if(30'h40, 1'b0);
        push_d(1'b0, 30'h80, 32'h0, 1'b0);
        for (int t = 0; t < 4; t++) begin
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (if_done || d_done) begin
                    got = 1'b1;
                    break;
                end
            end
            check("rr_wait", {63'b0, got}, 64'd1);
            if (!got) break;
            port = d_done;
            check("rr_owner", {63'b0, owner}, 64'(t % 2));
            check("rr_port", {63'b0, port}, 64'(t % 2));
            if (port) d_req = 1'b0;
            else      if_req = 1'b0;
            if (raised < 4) begin
                @(negedge clk);
                if (port) push_d(1'b0, 30'h80 + 30'(raised), 32'h0, 1'b0);
                else      push_if(30'h40 + 30'(raised), 1'b0);
                raised++;
            end
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        @(negedge clk);

        // Watchdog: memory never acks.
        lat = 0;
        push_if(30'h55, 1'b1);
        for (int c = 1; c <= TO; c++) begin
            @(negedge clk);
            check("to_m_req", {63'b0, m_req}, 64'd1);
        end
        @(negedge clk);
        check("to_done", {63'b0, if_done}, 64'd1);
        check("to_err", {63'b0, err}, 64'd1);
        check("to_m_req_off", {63'b0, m_req}, 64'd0);
        if_req = 1'b0;
        @(negedge clk);

        // Ack on the terminal-count cycle completes normally.
        lat = TO;
        push_d(1'b0, 30'h66, 32'h0, 1'b0);
        repeat (TO) @(negedge clk);
        @(negedge clk);
        check("tc_done", {63'b0, d_done}, 64'd1);
        check("tc_err", {63'b0, err}, 64'd0);
        d_req = 1'b0;
        @(negedge clk);

        // Stray acks while idle.
        idle_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_if_done", {63'b0, if_done}, 64'd0);
            check("idle_d_done", {63'b0, d_done}, 64'd0);
        end
        idle_ack = 1'b0;
        repeat (2) @(negedge clk);

        // Reset in the middle of BUSY.
        lat = 0;
        push_if(30'h77, 1'b0);
        repeat (2) @(negedge clk);
        check("rb_busy", {63'b0, m_req}, 64'd1);
        rst = 1'b1;
        if_req = 1'b0;
        q_if.delete();
        exp_if_rdata = '0;
        exp_d_rdata  = '0;
        #1;
        check_reset_outputs("rb");
        @(negedge clk);
        rst = 1'b0;
        lat = 2;
        @(negedge clk);
        push_if(30'h12, 1'b0);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (if_done) begin
                got = 1'b1;
                break;
            end
        end
        check("ra_wait", {63'b0, got}, 64'd1);
        check("ra_owner", {63'b0, owner}, 64'd0);
        if_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares one single-port, variable-latency word memory between the instruction-fetch port and the data (load/store) port of the multicycle MIPS core. It holds the transaction until the memory acknowledges, then returns read data and a one-cycle completion pulse to the owning requester. It sits between the core's control FSM and a unified memory model. Arbitration is round-robin on simultaneous requests, and a watchdog aborts transactions the memory never acknowledges.

## Interface
- AW, 30, word-address width (byte address bits [31:2])
- DW, 32, data width
- TIMEOUT, 16, maximum cycles in BUSY waiting for m_ack; 0 disables the watchdog
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  instruction-fetch request, level, held until if_done
- if_addr  in  AW  fetch word address, stable while if_req is high
- if_rdata  out  DW  fetched word, valid when if_done is high, held afterwards
- if_done  out  1  one-cycle completion pulse for the fetch port
- d_req  in  1  data request, level, held until d_done
- d_we  in  1  1 = store, 0 = load; stable while d_req is high
- d_addr  in  AW  data word address
- d_wdata  in  DW  store data
- d_rdata  out  DW  load data, valid when d_done is high, held afterwards
- d_done  out  1  one-cycle completion pulse for the data port
- err  out  1  high together with if_done or d_done when the transaction timed out
- m_req  out  1  memory request, held high until m_ack
- m_we  out  1  memory write enable, qualified by m_req
- m_addr  out  AW  memory word address
- m_wdata  out  DW  memory write data
- m_rdata  in  DW  memory read data, sampled in the m_ack cycle
- m_ack  in  1  memory completion, one-cycle pulse; ignored outside BUSY
- owner  out  1  0 = fetch port, 1 = data port; the current or last grant

## Operation
- FSM states are IDLE, BUSY and DONE.
- In IDLE, any request causes a grant.
  - If only one port requests, that port wins.
  - If both request, the port other than last_owner wins.
  - last_owner resets to 1, so the first tie goes to fetch.
- On a grant, the arbiter latches owner, m_addr, m_we and m_wdata from the winning port.
  - A fetch grant forces m_we=0 and m_wdata=0.
  - The state moves to BUSY and the wait counter clears.
- In BUSY:
  - m_req is 1 and all m_* outputs are stable.
  - A cycle with m_ack=1 completes the transaction:
    - a read captures m_rdata into if_rdata or d_rdata, according to owner;
    - last_owner takes the value of owner;
    - the state moves to DONE.
  - A cycle without m_ack increments the wait counter.
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 without m_ack, the state moves to DONE with err set. rdata is not updated in this case.
- In DONE:
  - the owner's done output is 1 for exactly this cycle;
  - err is valid in this cycle;
  - m_req is 0;
  - the state moves to IDLE.
- A store never modifies d_rdata. A timed-out transaction never modifies either rdata output.
- The requester must drop its req before the IDLE cycle that follows DONE. A req still high in that IDLE cycle is treated as a new request.
- The non-owning request waits while the other port is served. Its inputs are sampled only at grant.

## Timing
- Reset values:
  - state IDLE, last_owner 1
  - m_req, m_we, if_done, d_done, err, owner all 0
  - m_addr, m_wdata, if_rdata, d_rdata all 0
- Asserting rst in any state, BUSY included, drops m_req immediately and discards the transaction. No done pulse is produced.
- All outputs are registered; there is no combinational path from input to output.
- Latency, with a req seen in IDLE at cycle 0:
  - m_req is high from cycle 1;
  - m_ack in cycle k≥1 gives done in cycle k+1;
  - IDLE is reached in cycle k+2.
- Minimum, with m_ack in cycle 1: done in cycle 2, next grant decision in cycle 3, for a back-to-back period of 3 cycles.
- Timeout with TIMEOUT=T: m_req is high in cycles 1..T, and done plus err occur in cycle T+1.
- An m_ack that arrives in the same cycle as the timeout terminal count takes priority: the transaction completes normally with err=0.
- Simultaneous requests alternate strictly: fetch, data, fetch, … while both are held.

## Test plan
- Fetch only, if_addr=0x10, memory acks in cycle 3 with m_rdata=0x2008000A:
  - m_req is high in cycles 1–3, m_addr=0x10, m_we=0;
  - if_done and if_rdata=0x2008000A in cycle 4;
  - d_done stays 0.
- Store, d_addr=0x20, d_wdata=0xDEADBEEF, ack after 1 cycle:
  - m_we=1 and m_wdata=0xDEADBEEF during BUSY;
  - d_done pulses;
  - d_rdata stays at its prior value.
- if_req and d_req raised in the same cycle and re-raised after each done, for 4 transactions:
  - owner sequence is 0,1,0,1;
  - each port's rdata equals the memory word at its own address.
- TIMEOUT=4, memory never acks:
  - m_req is high exactly in cycles 1–4;
  - done and err=1 in cycle 5;
  - rdata unchanged.
- m_ack pulses while IDLE:
  - no done, no rdata change.
- rst asserted mid-BUSY:
  - m_req drops asynchronously and all outputs return to their reset values;
  - after release, a new fetch completes normally and owner=0.
